pwm_peripheral: RTL and testbench

Consumes the five configuration registers produced by the SPI register block and drives 16 output pins. Each pin is either forced low, driven static high, or driven with a common PWM waveform. One shared 8-bit PWM counter runs from a prescaled system clock; 10 MHz / 13 / 256 gives about 3.0 kHz. The duty cycle is shadowed at period boundaries, so updates never produce runt pulses.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_prescaler.sv | 31 +++
 rtl/pwm_peripheral.sv | 69 ++++++
 tb/tb_pwm_peripheral.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral and the per-pin drive rule.
// Pure declarations; no timing or flow control of its own.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int unsigned PWM_CLK_DIV_DEFAULT = 13;
  localparam int N_PINS = 16;

  // Disabled pins are forced low regardless of mode.
  function automatic logic pin_drive(input logic en, input logic pm, input logic pwm);
    return en & (pm ? pwm : 1'b1);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divider: tick is high for one clk every CLK_DIV clk cycles.
// Latency: tick is combinational from the counter; no backpressure (free-running).
module pwm_prescaler #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // With CLK_DIV=1 DIV_LAST is 0, so the counter holds at 0 and tick stays high.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin low, static high, or a shared PWM with duty shadowed per period.
// Latency: out registered, 1 clk after inputs; no backpressure (free-running).
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic                 tick;
  logic                 boundary;
  logic                 pwm_sig;
  logic [N_PINS-1:0]    en;
  logic [N_PINS-1:0]    pm;
  logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [N_PINS-1:0]    out_q, out_d;
  logic                 period_start_q, period_start_d;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    en       = {en_reg_out_15_8, en_reg_out_7_0};
    pm       = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    boundary = tick && (pwm_cnt_q == '1);
    // Full scale is special-cased so duty 0xFF has no low step at count 255.
    pwm_sig  = (duty_shadow_q == DUTY_FULL) || (pwm_cnt_q < duty_shadow_q);

    pwm_cnt_d      = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
    duty_shadow_d  = boundary ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = boundary;

    out_d = '0;
    for (int i = 0; i < N_PINS; i++) begin
      out_d[i] = pin_drive(en[i], pm[i], pwm_sig);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: directed steps plus random register traffic against a cycle-count model.
// Outputs are sampled 1 time unit after each rising clk edge.
module tb_pwm_peripheral;

  localparam int DIV = 4;
  localparam int PER = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_lo, en_hi, pm_lo, pm_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_edges;
  logic [7:0]  m_shadow;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_lo),
    .en_reg_out_15_8 (en_hi),
    .en_reg_pwm_7_0  (pm_lo),
    .en_reg_pwm_15_8 (pm_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // After n edges since reset release the counter sits at step (n/DIV) mod 256.
  function automatic logic model_pwm(input int n, input logic [7:0] d);
    int s;
    s = (n / DIV) % 256;
    return (d == 8'hFF) || (s < int'(d));
  endfunction

  // One clk edge: predict out/period_start from the inputs and model, then compare.
  task automatic step();
    logic [15:0] en, pm, exp_out;
    logic        p, exp_ps;
    en = {en_hi, en_lo};
    pm = {pm_hi, pm_lo};
    p  = model_pwm(n_edges, m_shadow);
    for (int i = 0; i < 16; i++) exp_out[i] = en[i] & (pm[i] ? p : 1'b1);
    exp_ps = ((n_edges + 1) % PER == 0);
    if (exp_ps) m_shadow = duty;
    @(posedge clk);
    #1;
    n_edges++;
    check("out", out, exp_out);
    check("period_start", 16'(period_start), 16'(exp_ps));
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (period_start !== 1'b1 && k < 2 * PER);
    check("period_start_timeout", 16'(period_start), 16'h1);
  endtask

  task automatic count_high(input int bit_idx, output int hi, output int toggles);
    logic prev;
    prev    = out[bit_idx];
    hi      = 0;
    toggles = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (out[bit_idx]) hi++;
      if (out[bit_idx] !== prev) toggles++;
      prev = out[bit_idx];
    end
  endtask

  initial begin
    int hi, tg, hi2, tg2;

    rst_n = 1'b0;
    en_lo = 8'h00; en_hi = 8'h00; pm_lo = 8'h00; pm_hi = 8'h00; duty = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 16'h0000);
    check("reset_period_start", 16'(period_start), 16'h0);
    rst_n    = 1'b1;
    n_edges  = 0;
    m_shadow = 8'h00;

    // Static-high pins on the low byte, one clk latency.
    en_lo = 8'hFF;
    check("static_before_edge", out, 16'h0000);
    step();
    check("static_low_byte", out, 16'h00FF);

    // 50% duty on pin 0.
    en_lo = 8'h01; pm_lo = 8'h01; duty = 8'h80;
    wait_ps();
    count_high(0, hi, tg);
    check_int("duty80_high_clks", hi, 512);
    check("duty80_next_period_start", 16'(period_start), 16'h1);
    count_high(0, hi, tg);
    check_int("duty80_high_clks_2", hi, 512);

    // 0% and 100% over two full periods each, no transitions.
    duty = 8'h00;
    wait_ps(); wait_ps();
    count_high(0, hi, tg);
    count_high(0, hi2, tg2);
    check_int("duty00_high", hi + hi2, 0);
    check_int("duty00_toggles", tg + tg2, 0);
    duty = 8'hFF;
    wait_ps(); wait_ps();
    count_high(0, hi, tg);
    count_high(0, hi2, tg2);
    check_int("dutyFF_high", hi + hi2, 2 * PER);
    check_int("dutyFF_toggles", tg + tg2, 0);

    // Mid-period duty change is deferred to the next boundary.
    duty = 8'h40;
    wait_ps(); wait_ps();
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == 100 * DIV) duty = 8'hC0;
      step();
      if (out[0]) hi++;
    end
    check_int("midchange_old_period", hi, 64 * DIV);
    count_high(0, hi, tg);
    check_int("midchange_new_period", hi, 192 * DIV);

    // Upper byte: PWM mode everywhere, only pins 11..8 enabled.
    en_lo = 8'h00; pm_lo = 8'h00; en_hi = 8'h0F; pm_hi = 8'hFF; duty = 8'h80;
    wait_ps(); wait_ps();
    count_high(8, hi, tg);
    check_int("upper_pwm_high", hi, 512);
    check("upper_disabled_pins", out & 16'hF000, 16'h0000);
    en_hi = 8'h00;
    step();
    check("upper_cleared", out & 16'hFF00, 16'h0000);

    // Asynchronous reset mid-period with outputs high.
    en_lo = 8'hFF; pm_lo = 8'h00; en_hi = 8'h0F; pm_hi = 8'hFF; duty = 8'hFF;
    wait_ps(); wait_ps();
    for (int i = 0; i < 200 * DIV; i++) step();
    check("pre_reset_out", out, 16'h0FFF);
    rst_n = 1'b0;
    #1;
    check("async_reset_out", out, 16'h0000);
    check("async_reset_period_start", 16'(period_start), 16'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    n_edges  = 0;
    m_shadow = 8'h00;
    count_high(8, hi, tg);
    check_int("post_reset_first_period_low", hi, 0);
    count_high(8, hi, tg);
    check_int("post_reset_second_period_high", hi, PER);

    // Random register traffic, checked every cycle by the model.
    for (int i = 0; i < 6 * PER; i++) begin
      if ($urandom_range(63) == 0) begin
        en_lo = 8'($urandom); en_hi = 8'($urandom);
        pm_lo = 8'($urandom); pm_hi = 8'($urandom);
      end
      if ($urandom_range(127) == 0) duty = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
